// File: rtl/insn_decode_stage_pkg.sv
// Shared decode definitions: field widths/shifts, opcode class masks and the
// packed decoded-entry layout used by the decode stage and its field decoder.
package insn_decode_stage_pkg;

   localparam int unsigned LEN_INSN      = 32;
   localparam int unsigned LEN_OPECODE   = 7;
   localparam int unsigned SHIFT_OPECODE = 25;
   localparam int unsigned LEN_REGNO     = 5;
   localparam int unsigned SHIFT_RD      = 20;
   localparam int unsigned SHIFT_RS      = 15;
   localparam int unsigned LEN_CC        = 4;
   localparam int unsigned SHIFT_CC      = 11;
   localparam int unsigned LEN_IMMF      = 1;
   localparam int unsigned SHIFT_IMMF    = 10;
   localparam int unsigned LEN_IMM       = 10;
   localparam int unsigned SHIFT_IMM     = 0;
   localparam int unsigned LEN_IMM_EX    = 32;
   localparam int unsigned LEN_TAG       = 32;
   localparam int unsigned LEN_SHAMT     = 5;
   localparam int unsigned LEN_OCC       = 2;

   // Opcode classes, matched on opcode[6:3] (immediates) and opcode[6:5] (reserved)
   localparam logic [3:0] OPC_SIMM  = 4'b0000;
   localparam logic [3:0] OPC_SHIFT = 4'b0001;
   localparam logic [3:0] OPC_SIMM2 = 4'b0011;
   localparam logic [1:0] OPC_RSVD  = 2'b11;

   typedef struct packed {
      logic [LEN_OPECODE-1:0] opecode;
      logic                   is_nop;
      logic                   illegal;
      logic [LEN_IMMF-1:0]    immf;
      logic [LEN_REGNO-1:0]   rd;
      logic [LEN_REGNO-1:0]   rs;
      logic [LEN_CC-1:0]      cc;
      logic [LEN_IMM_EX-1:0]  imm;
   } dec_t;

   localparam int unsigned LEN_DEC = LEN_OPECODE + 2 + LEN_IMMF + 2 * LEN_REGNO
                                     + LEN_CC + LEN_IMM_EX;

   typedef struct packed {
      dec_t               dec;
      logic [LEN_TAG-1:0] tag;
   } entry_t;

   typedef enum logic [1:0] {
      IMM_ZERO,
      IMM_SEXT,
      IMM_ZEXT,
      IMM_SHAMT
   } imm_kind_e;

   // Immediate extension kind selected by immediate flag and opcode class
   function automatic imm_kind_e imm_kind(input logic [LEN_OPECODE-1:0] opc,
                                          input logic [LEN_IMMF-1:0]    immf);
      imm_kind_e k;
      if (immf == '0) begin
         k = IMM_ZERO;
      end else begin
         case (opc[6:3])
            OPC_SIMM, OPC_SIMM2: k = IMM_SEXT;
            OPC_SHIFT:           k = IMM_SHAMT;
            default:             k = IMM_ZEXT;
         endcase
      end
      return k;
   endfunction

endpackage

// File: rtl/insn_field_decode.sv
// Pure combinational instruction field decoder.
//   insn  : raw instruction
//   dec_o : packed dec_t (fields, nop/illegal flags, extended immediate)
module insn_field_decode
   import insn_decode_stage_pkg::*;
(
   input  logic [LEN_INSN-1:0] insn,
   output logic [LEN_DEC-1:0]  dec_o
);

   dec_t                d;
   logic [LEN_IMM-1:0]  imm_raw;
   logic [LEN_OPECODE-1:0] opc;
   logic [LEN_IMMF-1:0] immf;

   assign imm_raw = insn[SHIFT_IMM +: LEN_IMM];
   assign opc     = insn[SHIFT_OPECODE +: LEN_OPECODE];
   assign immf    = insn[SHIFT_IMMF +: LEN_IMMF];

   // Field extraction, classification and immediate extension
   always_comb begin
      d         = '0;
      d.opecode = opc;
      d.immf    = immf;
      d.rd      = insn[SHIFT_RD +: LEN_REGNO];
      d.rs      = insn[SHIFT_RS +: LEN_REGNO];
      d.cc      = insn[SHIFT_CC +: LEN_CC];
      d.is_nop  = (opc == '0);
      d.illegal = (opc[6:5] == OPC_RSVD);
      case (imm_kind(opc, immf))
         IMM_SEXT:  d.imm = LEN_IMM_EX'($signed(imm_raw));
         IMM_ZEXT:  d.imm = LEN_IMM_EX'(imm_raw);
         IMM_SHAMT: d.imm = LEN_IMM_EX'(imm_raw[LEN_SHAMT-1:0]);
         default:   d.imm = '0;
      endcase
   end

   assign dec_o = d;

endmodule

// File: rtl/insn_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer between fetch and issue.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop all buffered entries; blocks same-cycle accept
//   in_valid/in_ready : fetch handshake (insn, in_tag)
//   out_valid/out_ready : issue handshake (decoded fields, tag_o)
//   occupancy_o       : number of entries held (0..2)
module insn_decode_stage
   import insn_decode_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LEN_INSN-1:0]    insn,
   input  logic [LEN_TAG-1:0]     in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LEN_OPECODE-1:0] opecode_o,
   output logic                   is_nop_o,
   output logic                   illegal_o,
   output logic [LEN_IMMF-1:0]    immf_o,
   output logic [LEN_REGNO-1:0]   rd_o,
   output logic [LEN_REGNO-1:0]   rs_o,
   output logic [LEN_CC-1:0]      cc_o,
   output logic [LEN_IMM_EX-1:0]  imm_o,
   output logic [LEN_TAG-1:0]     tag_o,
   output logic [LEN_OCC-1:0]     occupancy_o
);

   logic [LEN_DEC-1:0] dec_w;
   entry_t             new_e;
   entry_t             main_q, main_d, skid_q, skid_d;
   logic               main_valid_q, main_valid_d;
   logic               skid_valid_q, skid_valid_d;
   logic               in_ready_q, in_ready_d;
   logic [LEN_OCC-1:0] occ_q, occ_d;
   logic               accept, xfer;

   insn_field_decode u_field_decode (
      .insn  (insn),
      .dec_o (dec_w)
   );

   always_comb begin
      new_e.dec = dec_t'(dec_w);
      new_e.tag = in_tag;
   end

   // Ready comes from a flop; flush and reset only ever force it low
   assign in_ready = in_ready_q & ~flush & ~rst;
   assign accept   = in_valid & in_ready;
   assign xfer     = main_valid_q & out_ready;

   // Buffer next state: main drives outputs, skid absorbs one stalled accept
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (xfer) begin
         // A full skid implies in_ready was low, so no accept can coincide
         if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_d = new_e;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (main_valid_q) begin
            skid_d       = new_e;
            skid_valid_d = 1'b1;
         end else begin
            main_d       = new_e;
            main_valid_d = 1'b1;
         end
      end
      in_ready_d = ~skid_valid_d;
      occ_d      = LEN_OCC'(main_valid_d) + LEN_OCC'(skid_valid_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         occ_q        <= '0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         occ_q        <= occ_d;
      end
   end

   assign out_valid   = main_valid_q;
   assign opecode_o   = main_q.dec.opecode;
   assign is_nop_o    = main_q.dec.is_nop;
   assign illegal_o   = main_q.dec.illegal;
   assign immf_o      = main_q.dec.immf;
   assign rd_o        = main_q.dec.rd;
   assign rs_o        = main_q.dec.rs;
   assign cc_o        = main_q.dec.cc;
   assign imm_o       = main_q.dec.imm;
   assign tag_o       = main_q.tag;
   assign occupancy_o = occ_q;

endmodule

// File: tb/tb_insn_decode_stage.sv
// Bench for insn_decode_stage: directed steps plus random traffic checked
// against a queue-based reference (capacity-2 FIFO) and arithmetic decode.
module tb_insn_decode_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] insn;
   logic [31:0] in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  opecode_o;
   logic        is_nop_o;
   logic        illegal_o;
   logic [0:0]  immf_o;
   logic [4:0]  rd_o;
   logic [4:0]  rs_o;
   logic [3:0]  cc_o;
   logic [31:0] imm_o;
   logic [31:0] tag_o;
   logic [1:0]  occupancy_o;

   int          n_vec;
   int          n_miss;
   int          n_xfer;
   logic [87:0] mq[$];
   logic [87:0] last;
   logic [31:0] ta, tb_, tc;

   insn_decode_stage dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .insn        (insn),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .opecode_o   (opecode_o),
      .is_nop_o    (is_nop_o),
      .illegal_o   (illegal_o),
      .immf_o      (immf_o),
      .rd_o        (rd_o),
      .rs_o        (rs_o),
      .cc_o        (cc_o),
      .imm_o       (imm_o),
      .tag_o       (tag_o),
      .occupancy_o (occupancy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Expected output vector {opc,nop,illegal,immf,rd,rs,cc,imm,tag}
   function automatic logic [87:0] ref_out(input logic [31:0] i, input logic [31:0] t);
      int unsigned opc, immf, imm, rd, rs, cc;
      logic [31:0] ex;
      opc  = i >> 25;
      immf = (i >> 10) & 1;
      imm  = i & 32'h3FF;
      rd   = (i >> 20) & 31;
      rs   = (i >> 15) & 31;
      cc   = (i >> 11) & 15;
      if (immf == 0)                         ex = 0;
      else if (opc / 8 == 0 || opc / 8 == 3) ex = (imm >= 512) ? imm + 32'hFFFF_FC00 : imm;
      else if (opc / 8 == 1)                 ex = imm % 32;
      else                                   ex = imm;
      return {7'(opc), 1'(opc == 0), 1'(opc >= 96), 1'(immf), 5'(rd), 5'(rs), 4'(cc), ex, t};
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic immf, input logic [9:0] imm);
      logic [31:0] r;
      r       = $urandom;
      r[31:25] = opc;
      r[10]    = immf;
      r[9:0]   = imm;
      return r;
   endfunction

   // One clock: check ready, advance reference on the edge, check outputs
   task automatic cycle();
      logic exp_rdy;
      #1;
      exp_rdy = !rst && !flush && (mq.size() < 2);
      chk("in_ready", 128'(in_ready), 128'(exp_rdy));
      if (out_valid === 1'b1 && out_ready) n_xfer++;
      @(posedge clk);
      if (rst || flush) begin
         mq.delete();
         if (rst) last = '0;
      end else begin
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (in_valid && exp_rdy) mq.push_back(ref_out(insn, in_tag));
      end
      #1;
      n_vec++;
      chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
      chk("occupancy", 128'(occupancy_o), 128'(mq.size()));
      if (mq.size() > 0) last = mq[0];
      chk("data", 128'({opecode_o, is_nop_o, illegal_o, immf_o, rd_o, rs_o, cc_o, imm_o, tag_o}),
          128'(last));
   endtask

   initial begin
      n_vec = 0; n_miss = 0; n_xfer = 0; last = '0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      insn = '0; in_tag = '0;

      // Reset for two cycles
      cycle(); cycle();
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_occ", 128'(occupancy_o), 128'(0));
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      cycle();

      // Immediate rules, one insn at a time
      out_ready = 1'b1;
      in_valid = 1'b1; insn = mk(7'b000_0001, 1'b1, 10'h3FF); in_tag = $urandom;
      cycle(); in_valid = 1'b0;
      chk("imm_sext", 128'(imm_o), 128'(32'hFFFF_FFFF));
      in_valid = 1'b1; insn = mk(7'b000_1000, 1'b1, 10'h3E5); in_tag = $urandom;
      cycle(); in_valid = 1'b0;
      chk("imm_shamt", 128'(imm_o), 128'(32'h5));
      in_valid = 1'b1; insn = mk(7'b010_0000, 1'b1, 10'h3FF); in_tag = $urandom;
      cycle(); in_valid = 1'b0;
      chk("imm_zext", 128'(imm_o), 128'(32'h3FF));
      in_valid = 1'b1; insn = mk(7'b001_1010, 1'b1, 10'h200); in_tag = $urandom;
      cycle(); in_valid = 1'b0;
      chk("imm_sext2", 128'(imm_o), 128'(32'hFFFF_FE00));
      in_valid = 1'b1; insn = mk(7'b000_0001, 1'b0, 10'h3FF); in_tag = $urandom;
      cycle(); in_valid = 1'b0;
      chk("imm_noflag", 128'(imm_o), 128'(0));

      // Flags
      in_valid = 1'b1; insn = mk(7'h00, 1'b0, 10'h0); in_tag = $urandom;
      cycle(); in_valid = 1'b0;
      chk("is_nop", 128'(is_nop_o), 128'(1));
      in_valid = 1'b1; insn = mk(7'b110_0000, 1'b0, 10'h0); in_tag = $urandom;
      cycle(); in_valid = 1'b0;
      chk("illegal", 128'(illegal_o), 128'(1));
      cycle();

      // Back-pressure: A,B accepted, C stalls
      out_ready = 1'b0;
      ta = $urandom; tb_ = $urandom; tc = $urandom;
      in_valid = 1'b1; insn = $urandom; in_tag = ta;  cycle();
      insn = $urandom; in_tag = tb_; cycle();
      insn = $urandom; in_tag = tc;  cycle();
      chk("bp_occ2", 128'(occupancy_o), 128'(2));
      chk("bp_ready0", 128'(in_ready), 128'(0));
      chk("bp_headA", 128'(tag_o), 128'(ta));
      out_ready = 1'b1;
      cycle();
      chk("bp_B", 128'(tag_o), 128'(tb_));
      cycle(); in_valid = 1'b0;
      chk("bp_C", 128'(tag_o), 128'(tc));
      cycle(); cycle();

      // Throughput: 8 back-to-back accepts drain in 8 consecutive cycles
      n_xfer = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         insn = $urandom; in_tag = $urandom;
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      chk("throughput", 128'(n_xfer), 128'(8));
      cycle();

      // Flush with two entries held and a pending insn
      out_ready = 1'b0; in_valid = 1'b1;
      insn = $urandom; in_tag = $urandom; cycle();
      insn = $urandom; in_tag = $urandom; cycle();
      flush = 1'b1; insn = $urandom; in_tag = $urandom;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 128'(out_valid), 128'(0));
      chk("flush_occ", 128'(occupancy_o), 128'(0));
      out_ready = 1'b1;
      cycle(); cycle();

      // Random traffic including occasional flush and reset
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         insn      = $urandom;
         in_tag    = $urandom;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
